// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with valid/ready handshake, flush,
// bubble-gated control outputs and a saturating stall counter.
// Optional one-entry skid buffer when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid & out_ready;

  // Bubbles present all-zero control so they can never write state downstream.
  assign out_valid = r_valid;
  assign out_ctrl  = r_valid ? r_ctrl : '0;
  assign out_data  = r_data;
  assign out_pc    = r_pc;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_skid_pc;

  // Ready depends only on registers, cutting the out_ready -> in_ready path.
  assign in_ready = !flush && !r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_data       <= '0;
      r_pc         <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_fire && r_skid_valid) begin
      r_ctrl <= r_skid_ctrl;
      r_data <= r_skid_data;
      r_pc   <= r_skid_pc;
      if (w_in_fire) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
        r_skid_pc   <= in_pc;
      end else begin
        r_skid_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (r_valid && !w_out_fire) begin
        r_skid_ctrl  <= in_ctrl;
        r_skid_data  <= in_data;
        r_skid_pc    <= in_pc;
        r_skid_valid <= 1'b1;
      end else begin
        r_ctrl  <= in_ctrl;
        r_data  <= in_data;
        r_pc    <= in_pc;
        r_valid <= 1'b1;
      end
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !flush && (!r_valid || out_ready);

  // Payload loads only on input fire; it stays stale while the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_ctrl  <= in_ctrl;
      r_data  <= in_data;
      r_pc    <= in_pc;
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with CNT_W=4 shares
// the stimulus to exercise stall counter saturation.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]  stall_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [PC_W-1:0]   s_out_pc;
  logic [3:0]        s_stall_cnt;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_pc(s_out_pc),
    .stall_cnt(s_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'h1F; in_data = 32'h55; in_pc = 32'h400;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 5'h00) $display("FAIL reset_ctrl: got %h want 00", out_ctrl); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] exp_d;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = CTRL_W'(i + 1);
      in_data = DATA_W'(32'h10 + i); in_pc = PC_W'(32'h100 + 4 * i);
      step();
      exp_d = DATA_W'(32'h10 + i);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %0b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_d) $display("FAIL stream_data%0d: got %h want %h", i, out_data, exp_d); else n_pass++;
      n_checks++; if (out_ctrl !== CTRL_W'(i + 1)) $display("FAIL stream_ctrl%0d: got %h want %h", i, out_ctrl, CTRL_W'(i + 1)); else n_pass++;
    end
    n_checks++; if (out_pc !== 32'h108) $display("FAIL stream_pc: got %h want 108", out_pc); else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 5'h00) $display("FAIL stream_bubble_ctrl: got %h want 00", out_ctrl); else n_pass++;
    n_checks++; if (out_data !== 32'h12) $display("FAIL stream_stale_data: got %h want 12", out_data); else n_pass++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'h12; in_data = 32'hAB; in_pc = 32'h200;
    step();
    in_ctrl = 5'h03; in_data = 32'hCD; in_pc = 32'h204;
`ifdef PIPE_STAGE_SKID_EN
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_skid_accept: got %0b want 1", in_ready); else n_pass++;
`else
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %0b want 0", in_ready); else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_data !== 32'hAB) $display("FAIL stall_hold%0d: got %h want ab", i, out_data); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready%0d: got %0b want 0", i, in_ready); else n_pass++;
    end
    n_checks++; if (stall_cnt !== 16'd4) $display("FAIL stall_cnt: got %0d want 4", stall_cnt); else n_pass++;
    n_checks++; if (out_ctrl !== 5'h12) $display("FAIL stall_ctrl: got %h want 12", out_ctrl); else n_pass++;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 32'hCD) $display("FAIL stall_order_data: got %h want cd", out_data); else n_pass++;
    n_checks++; if (out_ctrl !== 5'h03) $display("FAIL stall_order_ctrl: got %h want 03", out_ctrl); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd4) $display("FAIL stall_cnt_release: got %0d want 4", stall_cnt); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'h1F; in_data = 32'h77; in_pc = 32'h300;
    step();
    in_ctrl = 5'h05; in_data = 32'h88; in_pc = 32'h304; flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", in_ready); else n_pass++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 5'h00) $display("FAIL flush_ctrl: got %h want 00", out_ctrl); else n_pass++;
    n_checks++; if (out_data !== 32'h77) $display("FAIL flush_no_capture: got %h want 77", out_data); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd5) $display("FAIL flush_stall_cnt: got %0d want 5", stall_cnt); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_stays_empty: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 5'h01; in_data = 32'h99; in_pc = 32'h500;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_reach: got %0d want 15", s_stall_cnt); else n_pass++;
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd25) $display("FAIL sat_wide_cnt: got %0d want 25", stall_cnt); else n_pass++;
    n_checks++; if (s_out_valid !== 1'b1) $display("FAIL sat_valid: got %0b want 1", s_out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd0) $display("FAIL rstmid_cnt: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (s_stall_cnt !== 4'd0) $display("FAIL rstmid_sat_cnt: got %0d want 0", s_stall_cnt); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL rstmid_data: got %h want 0", out_data); else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_emit: got %0b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; in_pc = '0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
